if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC, drives the instruction-memory request, and captures the fetched word into the IF/ID register.
- Presents the captured instruction's Rs/Rt fields to the hazard unit.
- Obeys separate stall (load-use) and flush/redirect (jump or taken branch) controls from downstream.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, consecutive not-ready cycles after which FetchFault sets (range 1..255).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- Stall  input  1  hold PC and IF/ID (load-use hazard).
- Redirect  input  1  jump or taken branch resolved this cycle.
- RedirectPC  input  32  target PC, valid when Redirect=1.
- ImemAddr  output  32  fetch address; equals the PC register, combinational.
- ImemReq  output  1  fetch request.
- ImemReady  input  1  ImemData valid this cycle.
- ImemData  input  32  instruction word from instruction memory.
- IDValid  output  1  IF/ID holds a real instruction (0 = bubble).
- IDInstr  output  32  IF/ID instruction; 32'h0 (NOP) when bubble.
- IDPC  output  32  PC of IDInstr.
- IDPCPlus4  output  32  IDPC+4.
- IFRs  output  5  IDInstr[25:21], combinational from the register.
- IFRt  output  5  IDInstr[20:16], combinational from the register.
- FetchFault  output  1  sticky instruction-memory timeout flag.
- MisalignErr  output  1  sticky flag: a RedirectPC had nonzero bits [1:0].

Behaviour:
- Reset (rst=1 at an edge):
  - PC=RESET_PC.
  - IDValid=0, IDInstr=0, IDPC=0, IDPCPlus4=0.
  - Wait counter=0, FetchFault=0, MisalignErr=0.
  - rst overrides every other input.
- ImemReq: 0 during the cycle rst is high; 1 otherwise.
- Per-edge priority (rst not asserted): Redirect > Stall > fetch.
- Redirect=1:
  - PC <= {RedirectPC[31:2],2'b00}.
  - If RedirectPC[1:0]!=0, MisalignErr <= 1.
  - IF/ID <= bubble.
  - Wait counter <= 0.
  - Applies even when Stall=1 or ImemReady=0 in the same cycle; the in-flight fetch is discarded.
- Redirect=0, Stall=1:
  - PC and IF/ID hold.
  - ImemData is ignored.
  - Wait counter holds.
- Redirect=0, Stall=0, ImemReady=1:
  - IF/ID <= {IDValid=1, IDInstr=ImemData, IDPC=PC, IDPCPlus4=PC+4}.
  - PC <= PC+4.
  - Wait counter <= 0.
- Redirect=0, Stall=0, ImemReady=0:
  - PC holds; IF/ID <= bubble.
  - Wait counter increments, saturating at IMEM_TIMEOUT.
  - When the counter reaches IMEM_TIMEOUT, FetchFault <= 1.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no carry out.
- Timing: zero-cycle combinational path ImemAddr=PC. Fetch-to-IF/ID latency is 1 edge when ImemReady=1.
- Sticky flags: FetchFault and MisalignErr clear only on rst.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined: Redirect does not bubble IF/ID. IF/ID follows the non-redirect rules (load if Stall=0 and ImemReady=1, hold if Stall=1, bubble if ImemReady=0), so the delay-slot instruction enters ID. PC still <= RedirectPC.
- Undefined: Redirect bubbles IF/ID as described above.

Test Plan:
- Reset then sequential fetch: rst high 2 cycles, then ImemReady=1, ImemData=32'h2408_0001, 32'h2409_0002 -> ImemAddr 32'h3000 then 32'h3004. IF/ID shows Instr 32'h2408_0001, IDPC 32'h3000, IDPCPlus4 32'h3004, IFRs=0, IFRt=8; next edge Instr 32'h2409_0002, IDPC 32'h3004.
- Stall: Stall=1 for 3 cycles while IDInstr=32'h8C28_0000 -> IDInstr, IDPC and ImemAddr unchanged for 3 edges; resumes at PC+4 on Stall=0.
- Redirect with simultaneous Stall: Redirect=1, RedirectPC=32'h0000_3040, Stall=1 -> next ImemAddr=32'h3040; IDValid=0, IDInstr=0 (macro undefined). With IF_DELAY_SLOT_EN, IF/ID holds its prior contents.
- Timeout: ImemReady=0 for 16 cycles with IMEM_TIMEOUT=16 -> FetchFault=1 after the 16th edge, not before. IDValid=0 throughout; PC unchanged. FetchFault stays 1 after ImemReady returns.
- Misalign and wrap: Redirect to 32'hFFFF_FFFE -> PC=32'hFFFF_FFFC and MisalignErr=1. One fetch later ImemAddr=32'h0000_0000 and IDPCPlus4=32'h0000_0000.
- Reset mid-operation: assert rst while Stall=1 and FetchFault=1 -> next edge PC=32'h3000, IDValid=0, both sticky flags cleared.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction
// memory (slave): address/request out, ready/data back.
interface if_stage_if;
  logic [31:0] ImemAddr;
  logic        ImemReq;
  logic        ImemReady;
  logic [31:0] ImemData;

  modport master (
    output ImemAddr,
    output ImemReq,
    input  ImemReady,
    input  ImemData
  );

  modport slave (
    input  ImemAddr,
    input  ImemReq,
    output ImemReady,
    output ImemData
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
// Holds the PC, issues fetches on the imem bus, captures fetched words into
// IF/ID, and tracks sticky fetch-timeout and misaligned-redirect flags.
// Priority per edge: rst > Redirect > Stall > fetch.
// Optional macro IF_DELAY_SLOT_EN: a redirect no longer bubbles IF/ID, so the
// delay-slot instruction proceeds into ID under the normal stall/fetch rules.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IDValid,
  output logic [31:0] IDInstr,
  output logic [31:0] IDPC,
  output logic [31:0] IDPCPlus4,
  output logic [4:0]  IFRs,
  output logic [4:0]  IFRt,
  output logic        FetchFault,
  output logic        MisalignErr
);

  localparam logic [7:0] TIMEOUT_C = 8'(IMEM_TIMEOUT);

  logic [31:0] pc_r, pc_nxt_s, pc_plus4_s;
  logic        id_valid_r, id_valid_nxt_s;
  logic [31:0] id_instr_r, id_instr_nxt_s;
  logic [31:0] id_pc_r, id_pc_nxt_s;
  logic [31:0] id_pc4_r, id_pc4_nxt_s;
  logic [7:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic        fetch_fault_r, fetch_fault_nxt_s;
  logic        misalign_r, misalign_nxt_s;
  logic        id_load_s, id_bubble_s;

  // PC+4 wraps naturally in 32 bits; the carry is dropped.
  assign pc_plus4_s = pc_r + 32'd4;

  // Decide whether IF/ID loads the fetched word, becomes a bubble, or holds.
  always_comb begin
    id_load_s   = 1'b0;
    id_bubble_s = 1'b0;
`ifdef IF_DELAY_SLOT_EN
    if (Stall) begin
      id_load_s   = 1'b0;
      id_bubble_s = 1'b0;
    end else begin
      id_load_s   = imem.ImemReady;
      id_bubble_s = ~imem.ImemReady;
    end
`else
    if (Redirect) begin
      id_load_s   = 1'b0;
      id_bubble_s = 1'b1;
    end else if (Stall) begin
      id_load_s   = 1'b0;
      id_bubble_s = 1'b0;
    end else begin
      id_load_s   = imem.ImemReady;
      id_bubble_s = ~imem.ImemReady;
    end
`endif
  end

  // Next-state for PC, wait counter and sticky flags.
  always_comb begin
    pc_nxt_s          = pc_r;
    wait_cnt_nxt_s    = wait_cnt_r;
    misalign_nxt_s    = misalign_r;
    if (Redirect) begin
      pc_nxt_s       = {RedirectPC[31:2], 2'b00};
      wait_cnt_nxt_s = 8'd0;
      misalign_nxt_s = misalign_r | (RedirectPC[1:0] != 2'b00);
    end else if (Stall) begin
      pc_nxt_s       = pc_r;
      wait_cnt_nxt_s = wait_cnt_r;
    end else if (imem.ImemReady) begin
      pc_nxt_s       = pc_plus4_s;
      wait_cnt_nxt_s = 8'd0;
    end else begin
      pc_nxt_s = pc_r;
      if (wait_cnt_r >= TIMEOUT_C) begin
        wait_cnt_nxt_s = TIMEOUT_C;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
      end
    end
    // The counter only reaches the limit by counting up a not-ready stretch.
    fetch_fault_nxt_s = fetch_fault_r | (wait_cnt_nxt_s == TIMEOUT_C);
  end

  // Next-state for the IF/ID register contents.
  always_comb begin
    id_valid_nxt_s = id_valid_r;
    id_instr_nxt_s = id_instr_r;
    id_pc_nxt_s    = id_pc_r;
    id_pc4_nxt_s   = id_pc4_r;
    if (id_load_s) begin
      id_valid_nxt_s = 1'b1;
      id_instr_nxt_s = imem.ImemData;
      id_pc_nxt_s    = pc_r;
      id_pc4_nxt_s   = pc_plus4_s;
    end else if (id_bubble_s) begin
      id_valid_nxt_s = 1'b0;
      id_instr_nxt_s = 32'h0000_0000;
      id_pc_nxt_s    = 32'h0000_0000;
      id_pc4_nxt_s   = 32'h0000_0000;
    end else begin
      id_valid_nxt_s = id_valid_r;
    end
  end

  // State register: synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_instr_r    <= 32'h0000_0000;
      id_pc_r       <= 32'h0000_0000;
      id_pc4_r      <= 32'h0000_0000;
      wait_cnt_r    <= 8'd0;
      fetch_fault_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      id_valid_r    <= id_valid_nxt_s;
      id_instr_r    <= id_instr_nxt_s;
      id_pc_r       <= id_pc_nxt_s;
      id_pc4_r      <= id_pc4_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      fetch_fault_r <= fetch_fault_nxt_s;
      misalign_r    <= misalign_nxt_s;
    end
  end

  assign imem.ImemAddr = pc_r;
  assign imem.ImemReq  = ~rst;
  assign IDValid       = id_valid_r;
  assign IDInstr       = id_instr_r;
  assign IDPC          = id_pc_r;
  assign IDPCPlus4     = id_pc4_r;
  assign IFRs          = id_instr_r[25:21];
  assign IFRt          = id_instr_r[20:16];
  assign FetchFault    = fetch_fault_r;
  assign MisalignErr   = misalign_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios from the fetch-stage
// behaviour plus randomized stimulus checked against a behavioural model.
module tb_if_stage;
  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IDValid;
  logic [31:0] IDInstr;
  logic [31:0] IDPC;
  logic [31:0] IDPCPlus4;
  logic [4:0]  IFRs;
  logic [4:0]  IFRt;
  logic        FetchFault;
  logic        MisalignErr;

  if_stage_if imem_bus();

  if_stage #(.RESET_PC(32'h0000_3000), .IMEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IDValid    (IDValid),
    .IDInstr    (IDInstr),
    .IDPC       (IDPC),
    .IDPCPlus4  (IDPCPlus4),
    .IFRs       (IFRs),
    .IFRt       (IFRt),
    .FetchFault (FetchFault),
    .MisalignErr(MisalignErr)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (what the stage should hold after each edge).
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  int          m_cnt;
  logic        m_ff;
  logic        m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the fetch-stage rules to the model for one rising edge.
  task automatic model_edge();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      m_pc = 32'h0000_3000; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_idpc4 = '0;
      m_cnt = 0; m_ff = 1'b0; m_mis = 1'b0;
    end else if (Redirect) begin
      if (RedirectPC % 4 != 0) m_mis = 1'b1;
      m_pc  = RedirectPC - (RedirectPC % 4);
      m_cnt = 0;
`ifdef IF_DELAY_SLOT_EN
      if (!Stall) begin
        if (imem_bus.ImemReady) begin
          m_valid = 1'b1; m_instr = imem_bus.ImemData; m_idpc = old_pc; m_idpc4 = old_pc + 32'd4;
        end else begin
          m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_idpc4 = '0;
        end
      end
`else
      m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_idpc4 = '0;
`endif
    end else if (Stall) begin
      // everything holds
    end else if (imem_bus.ImemReady) begin
      m_valid = 1'b1; m_instr = imem_bus.ImemData; m_idpc = old_pc; m_idpc4 = old_pc + 32'd4;
      m_pc = old_pc + 32'd4;
      m_cnt = 0;
    end else begin
      m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_idpc4 = '0;
      if (m_cnt < TB_TIMEOUT) m_cnt++;
      if (m_cnt == TB_TIMEOUT) m_ff = 1'b1;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    logic [31:0] ins;
    ins = m_instr;
    check_eq("ImemAddr",    imem_bus.ImemAddr, m_pc);
    check_eq("ImemReq",     {31'd0, imem_bus.ImemReq}, {31'd0, ~rst});
    check_eq("IDValid",     {31'd0, IDValid}, {31'd0, m_valid});
    check_eq("IDInstr",     IDInstr, m_instr);
    check_eq("IDPC",        IDPC, m_idpc);
    check_eq("IDPCPlus4",   IDPCPlus4, m_idpc4);
    check_eq("IFRs",        {27'd0, IFRs}, {27'd0, ins[25:21]});
    check_eq("IFRt",        {27'd0, IFRt}, {27'd0, ins[20:16]});
    check_eq("FetchFault",  {31'd0, FetchFault}, {31'd0, m_ff});
    check_eq("MisalignErr", {31'd0, MisalignErr}, {31'd0, m_mis});
  endtask

  // One clock edge with the currently driven inputs, then check.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] dat);
    rst = r; Stall = st; Redirect = rd; RedirectPC = rpc;
    imem_bus.ImemReady = rdy; imem_bus.ImemData = dat;
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [31:0] rpc;
    int r;
    m_pc = '0; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_idpc4 = '0;
    m_cnt = 0; m_ff = 1'b0; m_mis = 1'b0;

    // Reset for two cycles; request must be low while rst is high.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    #1;
    check_eq("req_in_rst", {31'd0, imem_bus.ImemReq}, 32'd0);
    step();
    step();
    check_eq("rst_pc", imem_bus.ImemAddr, 32'h0000_3000);
    check_eq("rst_valid", {31'd0, IDValid}, 32'd0);

    // Sequential fetch.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2408_0001);
    #1;
    check_eq("req_on", {31'd0, imem_bus.ImemReq}, 32'd1);
    check_eq("addr0", imem_bus.ImemAddr, 32'h0000_3000);
    step();
    check_eq("f1_instr", IDInstr, 32'h2408_0001);
    check_eq("f1_pc", IDPC, 32'h0000_3000);
    check_eq("f1_pc4", IDPCPlus4, 32'h0000_3004);
    check_eq("f1_rs", {27'd0, IFRs}, 32'd0);
    check_eq("f1_rt", {27'd0, IFRt}, 32'd8);
    check_eq("addr1", imem_bus.ImemAddr, 32'h0000_3004);
    imem_bus.ImemData = 32'h2409_0002;
    step();
    check_eq("f2_instr", IDInstr, 32'h2409_0002);
    check_eq("f2_pc", IDPC, 32'h0000_3004);

    // Stall for three edges with a load in IF/ID.
    imem_bus.ImemData = 32'h8C28_0000;
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_bus.ImemData = $urandom;
      step();
      check_eq("stall_instr", IDInstr, 32'h8C28_0000);
      check_eq("stall_pc", IDPC, 32'h0000_3008);
      check_eq("stall_addr", imem_bus.ImemAddr, 32'h0000_300C);
    end
    Stall = 1'b0;
    imem_bus.ImemData = 32'h0000_0020;
    step();
    check_eq("resume_pc", IDPC, 32'h0000_300C);
    check_eq("resume_addr", imem_bus.ImemAddr, 32'h0000_3010);

    // Redirect together with a stall.
    held_instr = IDInstr;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b1, 32'h1234_5678);
    step();
    check_eq("redir_addr", imem_bus.ImemAddr, 32'h0000_3040);
`ifdef IF_DELAY_SLOT_EN
    check_eq("redir_hold", IDInstr, held_instr);
`else
    check_eq("redir_valid", {31'd0, IDValid}, 32'd0);
    check_eq("redir_instr", IDInstr, 32'h0);
`endif

    // Instruction-memory timeout.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= TB_TIMEOUT; i++) begin
      step();
      check_eq("to_fault", {31'd0, FetchFault}, (i == TB_TIMEOUT) ? 32'd1 : 32'd0);
      check_eq("to_valid", {31'd0, IDValid}, 32'd0);
      check_eq("to_addr", imem_bus.ImemAddr, 32'h0000_3040);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
    step();
    check_eq("to_sticky", {31'd0, FetchFault}, 32'd1);

    // Misaligned redirect and PC wrap.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000);
    step();
    check_eq("mis_addr", imem_bus.ImemAddr, 32'hFFFF_FFFC);
    check_eq("mis_flag", {31'd0, MisalignErr}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2400_0000);
    step();
    check_eq("wrap_addr", imem_bus.ImemAddr, 32'h0000_0000);
    check_eq("wrap_pc4", IDPCPlus4, 32'h0000_0000);
    check_eq("wrap_pc", IDPC, 32'hFFFF_FFFC);

    // Reset during a stall with both sticky flags set.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    check_eq("mrst_addr", imem_bus.ImemAddr, 32'h0000_3000);
    check_eq("mrst_valid", {31'd0, IDValid}, 32'd0);
    check_eq("mrst_ff", {31'd0, FetchFault}, 32'd0);
    check_eq("mrst_mis", {31'd0, MisalignErr}, 32'd0);

    // Randomized traffic: a mostly-ready phase, then a mostly-stalled-memory phase.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      if (i < 300) begin
        drive(r < 1, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, rpc,
              $urandom_range(0, 99) < 75, $urandom);
      end else begin
        drive(r < 1, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3, rpc,
              $urandom_range(0, 99) < 5, $urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
